// File: rtl/memory_cycle_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
// The request stays asserted and the bus fields stay constant until dmem_ready completes it.
interface memory_cycle_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/memory_cycle.sv
// memory_cycle: RV32IM memory stage. Issues loads and stores over the dmem
// request/ready handshake, aligns and extends load data, and holds the MEM/WB register.
// Optional feature: define MEM_MISALIGN_TRAP_EN to flag misaligned half/word
// accesses in MisalignW instead of issuing them to memory.
//
// state  | meaning
// S_IDLE | no access outstanding; a memory op requests combinationally
// S_WAIT | request outstanding, pipeline stalled until dmem_ready
module memory_cycle #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidM,
    input  logic            RegWriteM,
    input  logic            MemWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic [2:0]      Funct3M,
    input  logic [4:0]      RdM,
    input  logic [XLEN-1:0] ALU_ResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] PCPlus4M,
    memory_cycle_if.master  dmem,
    output logic            StallM,
    output logic            ValidW,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] ALU_ResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [XLEN-1:0] PCPlus4W,
    output logic            MisalignW
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic            req, stall;
    logic [1:0]      a;
    logic            is_load, mem_op, mis, req_ok;
    logic [3:0]      be_store;
    logic [XLEN-1:0] wdata_lane;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_data;

    assign a       = ALU_ResultM[1:0];
    assign is_load = ResultSrcM == 2'b01;
    assign mem_op  = ValidM & (MemWriteM | is_load);

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = mem_op & (((Funct3M[1:0] == 2'b01) & a[0]) |
                           ((Funct3M[1:0] == 2'b10) & (a != 2'b00)));
`else
    assign mis = 1'b0;
`endif

    assign req_ok = mem_op & ~mis;

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next state plus raw request/stall, before reset gating.
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    req = 1'b1;
                    if (!dmem.dmem_ready) begin
                        stall   = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (dmem.dmem_ready) state_d = S_IDLE;
                else                 stall   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Store byte enables and lane replication by access size.
    always_comb begin
        be_store   = 4'b0000;
        wdata_lane = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                be_store   = 4'b0001 << a;
                wdata_lane = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_store   = a[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{WriteDataM[15:0]}};
            end
            2'b10:   be_store = 4'b1111;
            default: be_store = 4'b0000;
        endcase
    end

    // Reset gates the control outputs combinationally so a pending request drops at once.
    assign dmem.dmem_req   = rst & req;
    assign dmem.dmem_we    = rst & req & MemWriteM;
    assign dmem.dmem_be    = (rst & req) ? (MemWriteM ? be_store : 4'b1111) : 4'b0000;
    assign dmem.dmem_addr  = {ALU_ResultM[31:2], 2'b00};
    assign dmem.dmem_wdata = wdata_lane;
    assign StallM          = rst & stall;

    // Load lane select and sign/zero extension.
    always_comb begin
        case (a)
            2'b00:   byte_sel = dmem.dmem_rdata[7:0];
            2'b01:   byte_sel = dmem.dmem_rdata[15:8];
            2'b10:   byte_sel = dmem.dmem_rdata[23:16];
            default: byte_sel = dmem.dmem_rdata[31:24];
        endcase
        half_sel = a[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (Funct3M)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'h0, half_sel};
            3'b010:  load_data = dmem.dmem_rdata;
            default: load_data = '0;
        endcase
    end

    // MEM/WB register: copies M fields when not stalled, inserts a bubble while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ValidW      <= 1'b0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 2'b00;
            RdW         <= 5'd0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
            PCPlus4W    <= '0;
            MisalignW   <= 1'b0;
        end else if (StallM) begin
            ValidW    <= 1'b0;
            RegWriteW <= 1'b0;
            MisalignW <= 1'b0;
        end else begin
            ValidW      <= ValidM;
            RegWriteW   <= ValidM & RegWriteM & ~mis;
            ResultSrcW  <= ResultSrcM;
            RdW         <= RdM;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= (ValidM & is_load & ~mis) ? load_data : '0;
            PCPlus4W    <= PCPlus4M;
            MisalignW   <= mis;
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
module tb_memory_cycle;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ValidM = 0, RegWriteM = 0, MemWriteM = 0;
    logic [1:0]  ResultSrcM = 0;
    logic [2:0]  Funct3M = 0;
    logic [4:0]  RdM = 0;
    logic [31:0] ALU_ResultM = 0, WriteDataM = 0, PCPlus4M = 0;
    logic        StallM, ValidW, RegWriteW, MisalignW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W;

    memory_cycle_if bus();

    memory_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RdM(RdM),
        .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .dmem(bus), .StallM(StallM),
        .ValidW(ValidW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .MisalignW(MisalignW)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int stall_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic logic f_memop();
        return ValidM && (MemWriteM || ResultSrcM == 2'b01);
    endfunction

    function automatic logic f_mis();
`ifdef MEM_MISALIGN_TRAP_EN
        int a = int'(ALU_ResultM[1:0]);
        if (!f_memop()) return 1'b0;
        if (Funct3M[1:0] == 2'b01 && (a % 2) != 0) return 1'b1;
        if (Funct3M[1:0] == 2'b10 && a != 0) return 1'b1;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic f_req();
        return rst && f_memop() && !f_mis();
    endfunction

    function automatic logic [31:0] f_load();
        int          a = int'(ALU_ResultM[1:0]);
        logic [31:0] b = (bus.dmem_rdata >> (8 * a)) & 32'hFF;
        logic [31:0] h = (a >= 2) ? (bus.dmem_rdata >> 16) : (bus.dmem_rdata & 32'hFFFF);
        case (Funct3M)
            3'b000:  return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'b101:  return h;
            3'b010:  return bus.dmem_rdata;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] f_be();
        int a = int'(ALU_ResultM[1:0]);
        if (!MemWriteM) return 4'b1111;
        case (Funct3M[1:0])
            2'b00:   return 4'(1 << a);
            2'b01:   return (a >= 2) ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_wdata();
        case (Funct3M[1:0])
            2'b00:   return {4{WriteDataM[7:0]}};
            2'b01:   return {2{WriteDataM[15:0]}};
            default: return WriteDataM;
        endcase
    endfunction

    // ---------------- MEM/WB model ----------------
    logic        m_valid = 0, m_rw = 0, m_mis = 0;
    logic [1:0]  m_rs = 0;
    logic [4:0]  m_rd = 0;
    logic [31:0] m_alu = 0, m_rdat = 0, m_pc4 = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid = 0; m_rw = 0; m_mis = 0; m_rs = 0; m_rd = 0;
            m_alu = 0; m_rdat = 0; m_pc4 = 0;
        end else if (f_req() && !bus.dmem_ready) begin
            m_valid = 0; m_rw = 0; m_mis = 0;
        end else begin
            m_valid = ValidM;
            m_rw    = ValidM && RegWriteM && !f_mis();
            m_rs    = ResultSrcM;
            m_rd    = RdM;
            m_alu   = ALU_ResultM;
            m_pc4   = PCPlus4M;
            m_rdat  = (ValidM && ResultSrcM == 2'b01 && !f_mis()) ? f_load() : 32'h0;
            m_mis   = f_mis();
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("req", 32'(bus.dmem_req), 32'(f_req()));
        chk("stall", 32'(StallM), 32'(f_req() && !bus.dmem_ready));
        if (f_req()) begin
            chk("addr", bus.dmem_addr, {ALU_ResultM[31:2], 2'b00});
            chk("we", 32'(bus.dmem_we), 32'(MemWriteM));
            chk("be", 32'(bus.dmem_be), 32'(f_be()));
            if (MemWriteM) chk("wdata", bus.dmem_wdata, f_wdata());
        end else begin
            chk("we_idle", 32'(bus.dmem_we), 32'h0);
            chk("be_idle", 32'(bus.dmem_be), 32'h0);
        end
        chk("ValidW", 32'(ValidW), 32'(m_valid));
        chk("RegWriteW", 32'(RegWriteW), 32'(m_rw));
        chk("ResultSrcW", 32'(ResultSrcW), 32'(m_rs));
        chk("RdW", 32'(RdW), 32'(m_rd));
        chk("ALU_ResultW", ALU_ResultW, m_alu);
        chk("ReadDataW", ReadDataW, m_rdat);
        chk("PCPlus4W", PCPlus4W, m_pc4);
        chk("MisalignW", 32'(MisalignW), 32'(m_mis));
        if (StallM) stall_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic set_op(input logic v, rw, mw, input logic [1:0] rs, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] alu, wd, pc4, rdat,
                          input logic rdy);
        ValidM = v; RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; Funct3M = f3;
        RdM = rd; ALU_ResultM = alu; WriteDataM = wd; PCPlus4M = pc4;
        bus.dmem_rdata = rdat; bus.dmem_ready = rdy;
        stall_cnt = 0;
    endtask

    // Holds the op for nwait not-ready cycles, then one ready cycle; returns #1 after completion.
    task automatic run_op(input int nwait);
        for (int i = 0; i < nwait; i++) begin
            @(posedge clk); #1;
            if (i == nwait - 1) bus.dmem_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.dmem_rdata = 32'h0;
        bus.dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ValidW", 32'(ValidW), 32'h0);
        chk("reset_ALU", ALU_ResultW, 32'h0);
        chk("reset_req", 32'(bus.dmem_req), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // SB 0xA5 at 0x1003, zero-wait
        set_op(1, 0, 1, 2'b00, 3'b000, 5'd0, 32'h1003, 32'h1234_56A5, 32'h104, 32'h0, 1);
        #1;
        chk("sb_be", 32'(bus.dmem_be), 32'h8);
        chk("sb_wdata", bus.dmem_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", bus.dmem_addr, 32'h1000);
        run_op(0);
        chk("sb_stalls", stall_cnt, 0);

        // SH 0xBEEF at 0x1002, one wait
        set_op(1, 0, 1, 2'b00, 3'b001, 5'd0, 32'h1002, 32'h0000_BEEF, 32'h108, 32'h0, 0);
        #1;
        chk("sh_be", 32'(bus.dmem_be), 32'hC);
        chk("sh_wdata", bus.dmem_wdata, 32'hBEEF_BEEF);
        run_op(1);
        chk("sh_stalls", stall_cnt, 1);

        // LB at 0x2001, 3 wait cycles
        set_op(1, 1, 0, 2'b01, 3'b000, 5'd5, 32'h2001, 32'h0, 32'h10C, 32'h1234_80FF, 0);
        run_op(3);
        chk("lb_stalls", stall_cnt, 3);
        chk("lb_data", ReadDataW, 32'hFFFF_FF80);
        chk("lb_src", 32'(ResultSrcW), 32'h1);
        chk("lb_rd", 32'(RdW), 32'd5);

        // LBU same address, back-to-back
        set_op(1, 1, 0, 2'b01, 3'b100, 5'd6, 32'h2001, 32'h0, 32'h110, 32'h1234_80FF, 1);
        run_op(0);
        chk("lbu_data", ReadDataW, 32'h0000_0080);

        // LHU / LH at 0x2002
        set_op(1, 1, 0, 2'b01, 3'b101, 5'd7, 32'h2002, 32'h0, 32'h114, 32'h8001_0000, 0);
        run_op(2);
        chk("lhu_data", ReadDataW, 32'h0000_8001);
        set_op(1, 1, 0, 2'b01, 3'b001, 5'd8, 32'h2002, 32'h0, 32'h118, 32'h8001_0000, 1);
        run_op(0);
        chk("lh_data", ReadDataW, 32'hFFFF_8001);

        // ADD result 0x55, ready high in IDLE must be ignored
        set_op(1, 1, 0, 2'b00, 3'b000, 5'd9, 32'h55, 32'hFFFF_FFFF, 32'h11C, 32'hDEAD_0000, 1);
        #1;
        chk("add_noreq", 32'(bus.dmem_req), 32'h0);
        chk("add_nostall", 32'(StallM), 32'h0);
        run_op(0);
        chk("add_alu", ALU_ResultW, 32'h55);
        chk("add_rdata", ReadDataW, 32'h0);
        chk("add_rw", 32'(RegWriteW), 32'h1);

        // LW at 0x3002
`ifdef MEM_MISALIGN_TRAP_EN
        set_op(1, 1, 0, 2'b01, 3'b010, 5'd10, 32'h3002, 32'h0, 32'h120, 32'hDEAD_BEEF, 0);
        #1;
        chk("lw_mis_noreq", 32'(bus.dmem_req), 32'h0);
        run_op(0);
        chk("lw_mis_flag", 32'(MisalignW), 32'h1);
        chk("lw_mis_rw", 32'(RegWriteW), 32'h0);
        chk("lw_mis_valid", 32'(ValidW), 32'h1);
`else
        set_op(1, 1, 0, 2'b01, 3'b010, 5'd10, 32'h3002, 32'h0, 32'h120, 32'hDEAD_BEEF, 0);
        #1;
        chk("lw_addr", bus.dmem_addr, 32'h3000);
        run_op(1);
        chk("lw_rw", 32'(RegWriteW), 32'h1);
        chk("lw_data", ReadDataW, 32'hDEAD_BEEF);
        chk("lw_mis0", 32'(MisalignW), 32'h0);
`endif

        // Bubble with ready high
        set_op(0, 1, 1, 2'b01, 3'b010, 5'd11, 32'h4000, 32'h0, 32'h124, 32'h0, 1);
        run_op(0);
        chk("bubble_valid", 32'(ValidW), 32'h0);
        chk("bubble_rw", 32'(RegWriteW), 32'h0);

        // Reset during WAIT of a pending SW
        set_op(1, 0, 1, 2'b00, 3'b010, 5'd0, 32'h4000, 32'h1122_3344, 32'h128, 32'h0, 0);
        @(posedge clk); #1;
        chk("wait_req", 32'(bus.dmem_req), 32'h1);
        rst = 1'b0;
        #1;
        chk("rstw_req", 32'(bus.dmem_req), 32'h0);
        chk("rstw_stall", 32'(StallM), 32'h0);
        chk("rstw_be", 32'(bus.dmem_be), 32'h0);
        chk("rstw_valid", 32'(ValidW), 32'h0);
        chk("rstw_pc4", PCPlus4W, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        set_op(0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1);
        #1;
        chk("post_rst_we", 32'(bus.dmem_we), 32'h0);
        run_op(0);
        chk("post_rst_valid", 32'(ValidW), 32'h0);

        // Back-to-back LW then SW, each with one wait
        set_op(1, 1, 0, 2'b01, 3'b010, 5'd12, 32'h5004, 32'h0, 32'h200, 32'hCAFE_F00D, 0);
        run_op(1);
        chk("b2b_lw", ReadDataW, 32'hCAFE_F00D);
        set_op(1, 0, 1, 2'b00, 3'b010, 5'd0, 32'h5008, 32'h0BAD_F00D, 32'h204, 32'h0, 0);
        #1;
        chk("b2b_sw_req", 32'(bus.dmem_req), 32'h1);
        run_op(1);
        chk("b2b_sw_stalls", stall_cnt, 1);

        set_op(0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory stage of the RV32IM 5-stage pipeline: issues loads/stores to data memory over a request/ready handshake, aligns and sign/zero-extends load data, and holds the MEM/WB pipeline register that feeds the writeback stage. Stalls the pipeline while data memory is not ready. Outputs (`ResultSrcW`, `ALU_ResultW`, `ReadDataW`, `PCPlus4W`, `RegWriteW`, `RdW`) go directly to writeback and the register file.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 supported.

Ports:
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ValidM` in 1: instruction in MEM is real (0 = bubble).
- `RegWriteM` in 1: instruction writes `rd`.
- `MemWriteM` in 1: store.
- `ResultSrcM` in 2: 00 ALU, 01 load, 10 PC+4; 01 marks a load.
- `Funct3M` in 3: access size/sign.
- `RdM` in 5: destination register.
- `ALU_ResultM` in 32: effective address / ALU result.
- `WriteDataM` in 32: store data (rs2).
- `PCPlus4M` in 32: PC+4.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out 32: `{ALU_ResultM[31:2],2'b00}`.
- `dmem_be` out 4: byte enables (stores; 4'b1111 for loads).
- `dmem_wdata` out 32: store data replicated into lanes.
- `dmem_rdata` in 32: read word, valid when `dmem_ready`.
- `dmem_ready` in 1: completes the current request.
- `StallM` out 1: freeze IF/ID/EX and MEM inputs.
- `ValidW`, `RegWriteW` out 1; `ResultSrcW` out 2; `RdW` out 5; `ALU_ResultW`, `ReadDataW`, `PCPlus4W` out 32: MEM/WB register.
- `MisalignW` out 1: misaligned-access flag (see Configuration).

## Operation
- Memory op = `ValidM & (MemWriteM | ResultSrcM==2'b01)`; non-memory ops never touch the bus.
- FSM, two states:
  - IDLE: on memory op, `dmem_req`=1 combinationally. If `dmem_ready` same cycle → complete, stay IDLE. Else → WAIT, `StallM`=1.
  - WAIT: `dmem_req`=1, `StallM`=1 until `dmem_ready`; on ready → complete, `StallM`=0 that cycle, → IDLE.
- Upstream holds all M inputs stable while `StallM`=1; bus outputs stay constant throughout.
- Store byte lanes, `a=ALU_ResultM[1:0]`: SB (000) `be=1<<a`, wdata = byte ×4; SH (001) `be=a[1]?1100:0011`, wdata = half ×2; SW (010) `be=1111`.
- Load extract from `dmem_rdata`: LB 000 / LBU 100 use byte lane `a`, sign/zero extended; LH 001 / LHU 101 use half `a[1]`; LW 010 full word. Other funct3 → 0.
- MEM/WB register loads on each edge where `StallM`=0: copies M fields; `ReadDataW` = extracted load data (0 for non-loads).
- While `StallM`=1, MEM/WB loads a bubble: `ValidW`=0, `RegWriteW`=0, other W fields hold.
- `RegWriteW = RegWriteM & ValidM` on load.

## Timing
- Reset (`rst`=0): state IDLE; all W outputs 0; `StallM`, `dmem_req`, `dmem_we`, `dmem_be` forced 0 (asynchronously).
- Non-memory op: W outputs valid 1 cycle after entry.
- Memory op with N wait cycles (`dmem_ready` low N cycles): `StallM` high N cycles, W valid N+1 cycles after entry.
- `dmem_ready` ignored in IDLE without a request.
- Reset asserted in WAIT: request dropped immediately, no W update, IDLE on release.
- Back-to-back memory ops: new request issued the cycle after completion, no idle gap.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined: LH/LHU/SH with `a[0]`=1 or LW/SW with `a`≠0 → no `dmem_req`, no stall; W registers `ValidW`=1, `RegWriteW`=0, `MisalignW`=1 for one cycle.
- Undefined: low address bits beyond access size ignored (half uses `a[1]`, word ignores `a`); `MisalignW` tied 0.

## Test plan
- Reset mid-WAIT: SW pending, `rst`=0 → `dmem_req`=0, all W = 0; after release FSM IDLE, no spurious write.
- SB 0xA5 at 0x1003, zero-wait → `dmem_be`=1000, `dmem_wdata`=0xA5A5A5A5, `dmem_addr`=0x1000, `StallM` never high.
- LB at 0x2001, `dmem_rdata`=0x1234_80FF, 3 wait cycles → `StallM` high 3 cycles, W bubbles meanwhile, then `ReadDataW`=0xFFFFFF80, `ResultSrcW`=01.
- LHU at 0x2002, rdata 0x8001_0000 → `ReadDataW`=0x00008001; LH same → 0xFFFF8001.
- ADD result 0x55 with `ResultSrcM`=00 → next cycle `ALU_ResultW`=0x55, `ReadDataW`=0, no `dmem_req`.
- LW at 0x3002: macro on → `MisalignW`=1, `RegWriteW`=0, no request; macro off → request to 0x3000, `RegWriteW`=1.
